sti_so_receiver: RTL and testbench
==================================

// Module: sti_so_receiver
// PURPOSE
//  Serial-side sink for the STI_DAC so_data/so_valid stream. Deserializes each so_valid burst into a
//  right-aligned word, checks that the burst length is 8/16/24/32 bits, and queues {len,data} in a
//  small show-ahead FIFO for the checker/host side. Sits directly downstream of STI_DAC's serial output.
// PARAMETERS
//  FIFO_DEPTH  4   entries in the frame FIFO (power of 2, >=2)
//  MAX_BITS    32  longest legal burst; bit counter is 6 bits wide
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-low reset
//  so_data    in   1   serial bit, MSB first, from STI_DAC
//  so_valid   in   1   high for every cycle that carries a bit; a burst = contiguous high cycles
//  rx_rd      in   1   pop head entry (ignored when rx_empty)
//  err_clr    in   1   synchronous clear of err_len/err_ovf
//  rx_data    out  32  head entry data, right-aligned, unused upper bits 0
//  rx_len     out  2   head entry length code: 0=8,1=16,2=24,3=32 bits
//  rx_empty   out  1   FIFO empty
//  rx_full    out  1   FIFO full
//  rx_count   out  3   entries held (0..FIFO_DEPTH)
//  err_len    out  1   sticky: a burst ended with an illegal bit count
//  err_ovf    out  1   sticky: a legal burst was dropped because FIFO was full
// BEHAVIOUR
//  Reset (reset=0, async): FSM->IDLE, shift reg=0, bitcnt=0, FIFO ptrs/count=0; rx_empty=1, rx_full=0,
//   rx_count=0, rx_data=0, rx_len=0, err_len=0, err_ovf=0. Reset mid-burst discards the partial frame.
//  FSM states: IDLE, SHIFT, DISCARD.
//   IDLE:    so_valid=1 -> sreg<={31'b0,so_data}, bitcnt<=1, ->SHIFT; else stay.
//   SHIFT:   so_valid=1 & bitcnt<MAX_BITS -> sreg<={sreg[30:0],so_data}, bitcnt+1, stay.
//            so_valid=1 & bitcnt==MAX_BITS -> err_len<=1, ->DISCARD (33rd bit is the overflow).
//            so_valid=0 -> end of burst: evaluate, ->IDLE (same edge).
//   DISCARD: ignore so_data until so_valid=0, then ->IDLE; no FIFO write.
//  End-of-burst evaluation (edge where SHIFT samples so_valid=0):
//   bitcnt in {8,16,24,32}: len=bitcnt/8-1; push {len,sreg} if not full (or full with rx_rd same cycle);
//   otherwise drop the frame and set err_ovf<=1.
//   Any other bitcnt: no push, err_len<=1.
//  Bit order: first received bit ends at rx_data[8*(len+1)-1], last received bit at rx_data[0].
//  Back-to-back bursts need >=1 so_valid=0 cycle between them (STI_DAC always provides this);
//   a single low cycle is sufficient -- IDLE accepts a new first bit on the very next cycle.
//  Latency: last bit sampled at edge N; so_valid=0 sampled at edge N+1 writes FIFO; rx_empty falls
//   and head is visible after edge N+1.
//  FIFO: show-ahead; rx_data/rx_len reflect head combinationally from storage, 0 when empty.
//   Pop on rx_rd & !rx_empty. Simultaneous push+pop: both occur, rx_count unchanged (legal even when
//   full). rx_rd while empty: no effect, no error. Pointers wrap modulo FIFO_DEPTH.
//  rx_full = (rx_count==FIFO_DEPTH); rx_empty = (rx_count==0).
//  err_clr: clears both sticky flags; if an error event occurs in the same cycle, the set wins.
//  All outputs registered or decoded from registers; no so_* input reaches an output combinationally.
// TESTING
//  1 8-bit burst 1010_0011 MSB first -> 1 entry, rx_len=0, rx_data=32'h0000_00A3, rx_count=1.
//  2 bursts of 16/24/32 bits (16'hBEEF, 24'h12_3456, 32'hDEAD_BEEF), 1 idle cycle apart -> 3 entries
//    popped in order with rx_len=1,2,3 and exact data; rx_empty=1 after third pop.
//  3 12-bit burst -> no push, err_len=1; 40-bit burst -> DISCARD, err_len=1, no push; next legal
//    8-bit burst still captured; err_clr -> err_len=0.
//  4 five 8-bit bursts with no rx_rd (depth 4) -> rx_full=1, 5th dropped, err_ovf=1, entries 1-4 intact;
//    repeat with rx_rd asserted on the 5th push edge -> 5th accepted, rx_count stays 4, err_ovf=0.
//  5 reset pulled low after 5 bits of a burst and with 2 entries queued -> all outputs at reset values;
//    after release, the remainder of the old burst (so_valid still high) is captured as a new burst and
//    flagged err_len when it ends with an illegal length.
//  6 pointer wrap: 10 push/pop pairs with rx_rd on alternate cycles -> data order preserved, no errors.

Source files
------------

// File: rtl/sti_so_receiver.sv
`timescale 1ns/1ps
// Serial sink for the STI_DAC so_data/so_valid stream: deserializes each burst,
// checks for an 8/16/24/32-bit length and queues {len,data} in a show-ahead FIFO.
module sti_so_receiver #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_BITS   = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               so_data,
    input  logic                               so_valid,
    input  logic                               rx_rd,
    input  logic                               err_clr,
    output logic [31:0]                        rx_data,
    output logic [1:0]                         rx_len,
    output logic                               rx_empty,
    output logic                               rx_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    rx_count,
    output logic                               err_len,
    output logic                               err_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [5:0]    MAX_CNT  = 6'(MAX_BITS);

    typedef enum logic [1:0] {IDLE, SHIFT, DISCARD} state_t;

    state_t        state_q;
    logic [31:0]   sreg_q;
    logic [5:0]    bitcnt_q;
    logic [31:0]   mem_data_q [FIFO_DEPTH];
    logic [1:0]    mem_len_q  [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          err_len_q, err_ovf_q;

    logic       eob, len_ok, push, pop, ovf_evt, len_evt;
    logic [1:0] len_code;

    // End of burst is the first low so_valid seen while shifting.
    assign eob      = (state_q == SHIFT) && !so_valid;
    assign len_ok   = (bitcnt_q[2:0] == 3'd0) && (bitcnt_q != 6'd0) && (bitcnt_q <= MAX_CNT);
    assign len_code = 2'(bitcnt_q[5:3] - 3'd1);
    assign pop      = rx_rd && (count_q != '0);
    assign push     = eob && len_ok && ((count_q != FULL_CNT) || rx_rd);
    assign ovf_evt  = eob && len_ok && !push;
    assign len_evt  = (eob && !len_ok) ||
                      ((state_q == SHIFT) && so_valid && (bitcnt_q == MAX_CNT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            bitcnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (so_valid) begin
                        sreg_q   <= {31'b0, so_data};
                        bitcnt_q <= 6'd1;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!so_valid) begin
                        state_q <= IDLE;
                    end else if (bitcnt_q == MAX_CNT) begin
                        state_q <= DISCARD;
                    end else begin
                        sreg_q   <= {sreg_q[30:0], so_data};
                        bitcnt_q <= bitcnt_q + 6'd1;
                    end
                end
                DISCARD: begin
                    if (!so_valid) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_len_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // A set in the same cycle as err_clr takes priority.
            err_len_q <= len_evt | (err_len_q & ~err_clr);
            err_ovf_q <= ovf_evt | (err_ovf_q & ~err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= sreg_q;
            mem_len_q[wr_ptr_q]  <= len_code;
        end
    end

    assign rx_empty = (count_q == '0);
    assign rx_full  = (count_q == FULL_CNT);
    assign rx_count = count_q;
    assign rx_data  = rx_empty ? 32'd0 : mem_data_q[rd_ptr_q];
    assign rx_len   = rx_empty ? 2'd0  : mem_len_q[rd_ptr_q];
    assign err_len  = err_len_q;
    assign err_ovf  = err_ovf_q;

endmodule

// File: tb/tb_sti_so_receiver.sv
`timescale 1ns/1ps
// Bench for sti_so_receiver: directed scenarios plus random bursts, checked every
// cycle against a queue-based model of bursts and the frame FIFO.
module tb_sti_so_receiver;

    localparam int DEPTH = 4;

    logic        clk, reset, so_data, so_valid, rx_rd, err_clr;
    logic [31:0] rx_data;
    logic [1:0]  rx_len;
    logic        rx_empty, rx_full, err_len, err_ovf;
    logic [2:0]  rx_count;

    int checks = 0;
    int passes = 0;

    sti_so_receiver #(.FIFO_DEPTH(DEPTH), .MAX_BITS(32)) dut (
        .clk(clk), .reset(reset), .so_data(so_data), .so_valid(so_valid),
        .rx_rd(rx_rd), .err_clr(err_clr), .rx_data(rx_data), .rx_len(rx_len),
        .rx_empty(rx_empty), .rx_full(rx_full), .rx_count(rx_count),
        .err_len(err_len), .err_ovf(err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  len;
        logic [31:0] data;
    } ent_t;

    ent_t mq[$];
    bit   bq[$];
    bit   m_err_len, m_err_ovf;
    bit   ev_len, ev_ovf, pop_now, full_before;
    int   nbits;
    logic [31:0] acc;
    ent_t e;

    // Reference model: collect burst bits in a queue, judge the whole burst when it ends.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            bq.delete();
            m_err_len = 0;
            m_err_ovf = 0;
        end else begin
            ev_len = 0;
            ev_ovf = 0;
            full_before = (mq.size() == DEPTH);
            pop_now = rx_rd && (mq.size() > 0);
            if (pop_now) void'(mq.pop_front());
            if (so_valid) begin
                bq.push_back(so_data);
                if (bq.size() == 33) ev_len = 1;
            end else if (bq.size() > 0) begin
                nbits = bq.size();
                if (nbits <= 32) begin
                    if (nbits % 8 == 0) begin
                        acc = 0;
                        foreach (bq[i]) acc = {acc[30:0], bq[i]};
                        e.len  = 2'(nbits / 8 - 1);
                        e.data = acc;
                        if (!full_before || pop_now) mq.push_back(e);
                        else ev_ovf = 1;
                    end else begin
                        ev_len = 1;
                    end
                end
                bq.delete();
            end
            if (err_clr) begin
                m_err_len = 0;
                m_err_ovf = 0;
            end
            if (ev_len) m_err_len = 1;
            if (ev_ovf) m_err_ovf = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("cyc_empty", 32'(rx_empty), 32'(mq.size() == 0));
            chk("cyc_full",  32'(rx_full),  32'(mq.size() == DEPTH));
            chk("cyc_count", 32'(rx_count), 32'(mq.size()));
            chk("cyc_data",  rx_data, (mq.size() > 0) ? mq[0].data : 32'd0);
            chk("cyc_len",   32'(rx_len), (mq.size() > 0) ? 32'(mq[0].len) : 32'd0);
            chk("cyc_errlen", 32'(err_len), 32'(m_err_len));
            chk("cyc_errovf", 32'(err_ovf), 32'(m_err_ovf));
        end
    end

    task automatic cyc(input logic sv, input logic sd, input logic rd, input logic clr);
        so_valid = sv;
        so_data  = sd;
        rx_rd    = rd;
        err_clr  = clr;
        @(negedge clk);
    endtask

    task automatic send(input logic [63:0] bits, input int n, input logic rd_end);
        for (int i = n - 1; i >= 0; i--) cyc(1'b1, bits[i], 1'b0, 1'b0);
        cyc(1'b0, 1'b0, rd_end, 1'b0);
    endtask

    task automatic pop1();
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_empty"}, 32'(rx_empty), 32'd1);
        chk({tag, "_full"},  32'(rx_full),  32'd0);
        chk({tag, "_count"}, 32'(rx_count), 32'd0);
        chk({tag, "_data"},  rx_data,       32'd0);
        chk({tag, "_len"},   32'(rx_len),   32'd0);
        chk({tag, "_elen"},  32'(err_len),  32'd0);
        chk({tag, "_eovf"},  32'(err_ovf),  32'd0);
    endtask

    initial begin
        logic [63:0] rb;
        int n, sel;
        bit ph;
        reset = 1'b0;
        so_valid = 0; so_data = 0; rx_rd = 0; err_clr = 0;
        repeat (3) @(negedge clk);
        reset_vals("rst");
        reset = 1'b1;
        cyc(0, 0, 0, 0);

        // 1: single 8-bit burst
        send(64'hA3, 8, 1'b0);
        chk("s1_data", rx_data, 32'h0000_00A3);
        chk("s1_len", 32'(rx_len), 32'd0);
        chk("s1_count", 32'(rx_count), 32'd1);
        pop1();
        chk("s1_empty", 32'(rx_empty), 32'd1);

        // 2: 16/24/32-bit bursts one idle cycle apart
        send(64'hBEEF, 16, 1'b0);
        send(64'h12_3456, 24, 1'b0);
        send(64'hDEAD_BEEF, 32, 1'b0);
        chk("s2_count", 32'(rx_count), 32'd3);
        chk("s2_d0", rx_data, 32'h0000_BEEF);
        chk("s2_l0", 32'(rx_len), 32'd1);
        pop1();
        chk("s2_d1", rx_data, 32'h0012_3456);
        chk("s2_l1", 32'(rx_len), 32'd2);
        pop1();
        chk("s2_d2", rx_data, 32'hDEAD_BEEF);
        chk("s2_l2", 32'(rx_len), 32'd3);
        pop1();
        chk("s2_empty", 32'(rx_empty), 32'd1);

        // 3: illegal lengths
        send(64'hABC, 12, 1'b0);
        chk("s3_elen12", 32'(err_len), 32'd1);
        chk("s3_cnt12", 32'(rx_count), 32'd0);
        cyc(0, 0, 0, 1);
        chk("s3_clr1", 32'(err_len), 32'd0);
        send(64'hFF_FFFF_FFFF, 40, 1'b0);
        chk("s3_elen40", 32'(err_len), 32'd1);
        chk("s3_cnt40", 32'(rx_count), 32'd0);
        send(64'h3C, 8, 1'b0);
        chk("s3_after", rx_data, 32'h0000_003C);
        cyc(0, 0, 1, 1);
        chk("s3_clr2", 32'(err_len), 32'd0);

        // 4: overflow, then full with simultaneous pop
        for (int i = 1; i <= 5; i++) send(64'(8'h10 * i + i), 8, 1'b0);
        chk("s4_full", 32'(rx_full), 32'd1);
        chk("s4_ovf", 32'(err_ovf), 32'd1);
        chk("s4_cnt", 32'(rx_count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            chk("s4_ent", rx_data, 32'(8'h10 * i + i));
            pop1();
        end
        cyc(0, 0, 0, 1);
        chk("s4_clr", 32'(err_ovf), 32'd0);
        for (int i = 1; i <= 4; i++) send(64'(8'h60 + i), 8, 1'b0);
        send(64'h65, 8, 1'b1);
        chk("s4b_cnt", 32'(rx_count), 32'd4);
        chk("s4b_ovf", 32'(err_ovf), 32'd0);
        chk("s4b_head", rx_data, 32'h62);
        repeat (4) pop1();

        // 5: reset mid-burst with two entries queued
        send(64'h5A, 8, 1'b0);
        send(64'hC3, 8, 1'b0);
        rb = 64'hF0F0;
        for (int i = 15; i >= 11; i--) cyc(1'b1, rb[i], 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1 reset_vals("s5rst");
        @(negedge clk);
        for (int i = 9; i >= 9; i--) cyc(1'b1, rb[i], 1'b0, 1'b0);
        reset = 1'b1;
        for (int i = 8; i >= 0; i--) cyc(1'b1, rb[i], 1'b0, 1'b0);
        cyc(0, 0, 0, 0);
        chk("s5_elen", 32'(err_len), 32'd1);
        chk("s5_empty", 32'(rx_empty), 32'd1);
        cyc(0, 0, 0, 1);

        // 6: pointer wrap, rx_rd on alternate cycles
        ph = 0;
        for (int k = 0; k < 10; k++) begin
            rb = 64'($urandom_range(255));
            for (int i = 7; i >= 0; i--) begin
                cyc(1'b1, rb[i], ph, 1'b0);
                ph = ~ph;
            end
            cyc(1'b0, 1'b0, ph, 1'b0);
            ph = ~ph;
        end
        repeat (4) pop1();
        chk("s6_elen", 32'(err_len), 32'd0);
        chk("s6_eovf", 32'(err_ovf), 32'd0);
        chk("s6_empty", 32'(rx_empty), 32'd1);

        // random bursts of legal and illegal length
        for (int k = 0; k < 150; k++) begin
            sel = $urandom_range(5);
            if (sel < 4) n = 8 * (sel + 1);
            else n = $urandom_range(40, 1);
            rb = {$urandom(), $urandom()};
            for (int i = n - 1; i >= 0; i--)
                cyc(1'b1, rb[i], ($urandom_range(3) == 0), ($urandom_range(15) == 0));
            repeat ($urandom_range(3, 1))
                cyc(1'b0, 1'b0, ($urandom_range(3) == 0), ($urandom_range(15) == 0));
        end
        repeat (6) pop1();
        chk("end_empty", 32'(rx_empty), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
